// File: rtl/shift_register_pkg.sv
// Shared definitions for the universal shift register and its helpers:
// operation codes, shift counter width and prescaler sizing.
package shift_register_pkg;

  localparam logic [1:0] MODE_HOLD        = 2'b00;
  localparam logic [1:0] MODE_SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] MODE_SHIFT_RIGHT = 2'b10;
  localparam logic [1:0] MODE_LOAD        = 2'b11;

  localparam int               COUNT_W   = 8;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  // Width of a counter that runs 0..tick_div-1; never narrower than one bit.
  function automatic int prescaler_width(input int tick_div);
    return (tick_div > 1) ? $clog2(tick_div) : 1;
  endfunction

endpackage

// File: rtl/shift_register_universal_if.sv
// Board-side signal bundle of the universal shift register: switch inputs
// in, LED bank / chain outputs / status out.
interface shift_register_universal_if #(
  parameter int WIDTH = 16
);
  import shift_register_pkg::*;

  logic [1:0]         mode;
  logic               serial_in;
  logic [WIDTH-1:0]   parallel_in;
  logic [WIDTH-1:0]   parallel_out;
  logic               serial_out_msb;
  logic               serial_out_lsb;
  logic               tick;
  logic [COUNT_W-1:0] shift_count;

  // Switch side: drives the controls, observes the register.
  modport master (
    output mode, serial_in, parallel_in,
    input  parallel_out, serial_out_msb, serial_out_lsb, tick, shift_count
  );

  // Register side.
  modport slave (
    input  mode, serial_in, parallel_in,
    output parallel_out, serial_out_msb, serial_out_lsb, tick, shift_count
  );

endinterface

// File: rtl/tick_generator.sv
// Divides the board clock down to a one-cycle update strobe every TICK_DIV
// cycles. The strobe is registered so downstream logic sees no glitches.
module tick_generator
  import shift_register_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk_100MHz,
  input  logic reset_n,
  output logic tick
);

  localparam int               DIV_W    = prescaler_width(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick_q, tick_d;

  // Wrap the prescaler at TICK_DIV-1 and flag the wrap cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    div_cnt_d = div_cnt_q + DIV_W'(1);
    tick_d    = 1'b0;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      tick_d    = 1'b1;
    end
  end

  // Prescaler and strobe registers.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/shift_register_universal.sv
// Universal shift register: hold / shift left / shift right / parallel
// load, updated once per prescaler tick from synchronised switch inputs,
// with a saturating count of shifts since reset or the last load.
module shift_register_universal
  import shift_register_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               TICK_DIV    = 100_000_000,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input logic                       clk_100MHz,
  input logic                       reset_n,
  shift_register_universal_if.slave bus
);

  // Two-stage synchronisers; the *_s_q stage is the only copy used downstream.
  logic [1:0]       mode_meta_q,     mode_s_q;
  logic             serial_meta_q,   serial_s_q;
  logic [WIDTH-1:0] parallel_meta_q, parallel_s_q;

  logic               tick;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [COUNT_W-1:0] count_q, count_d;

  // Bring the asynchronous switch inputs into the clock domain.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      mode_meta_q     <= '0;
      mode_s_q        <= '0;
      serial_meta_q   <= 1'b0;
      serial_s_q      <= 1'b0;
      parallel_meta_q <= '0;
      parallel_s_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the other's
      // pre-edge value; blocking ones would collapse the chain to one flop.
      mode_meta_q     <= bus.mode;
      mode_s_q        <= mode_meta_q;
      serial_meta_q   <= bus.serial_in;
      serial_s_q      <= serial_meta_q;
      parallel_meta_q <= bus.parallel_in;
      parallel_s_q    <= parallel_meta_q;
    end
  end

  tick_generator #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_generator (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .tick       (tick)
  );

  // Next register contents and shift count; only a tick cycle changes them.
  always_comb begin
    shreg_d = shreg_q;
    count_d = count_q;
    if (tick) begin
      case (mode_s_q)
        MODE_HOLD: begin
          shreg_d = shreg_q;
        end
        MODE_SHIFT_LEFT: begin
          shreg_d = {shreg_q[WIDTH-2:0], serial_s_q};
          count_d = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_W'(1);
        end
        MODE_SHIFT_RIGHT: begin
          shreg_d = {serial_s_q, shreg_q[WIDTH-1:1]};
          count_d = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_W'(1);
        end
        MODE_LOAD: begin
          shreg_d = parallel_s_q;
          count_d = '0;
        end
      endcase
    end
  end

  // Register and shift count state.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= RESET_VALUE;
      count_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      count_q <= count_d;
    end
  end

  assign bus.parallel_out   = shreg_q;
  assign bus.serial_out_msb = shreg_q[WIDTH-1];
  assign bus.serial_out_lsb = shreg_q[0];
  assign bus.tick           = tick;
  assign bus.shift_count    = count_q;

endmodule

// File: tb/tb_shift_register_universal.sv
// Self-checking bench: a 16-bit / TICK_DIV=4 instance and a 2-bit /
// TICK_DIV=1 instance run side by side against a cycle-count based model,
// plus literal expectations for the directed scenarios.
module tb_shift_register_universal;
  import shift_register_pkg::*;

  logic clk_100MHz = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk_100MHz = ~clk_100MHz;
  always @(posedge clk_100MHz) cyc++;

  shift_register_universal_if #(.WIDTH(16)) bus16 ();
  shift_register_universal_if #(.WIDTH(2))  bus2 ();

  logic [1:0]  drv_mode [2];
  logic        drv_ser  [2];
  logic [15:0] drv_par  [2];

  assign bus16.mode        = drv_mode[0];
  assign bus16.serial_in   = drv_ser[0];
  assign bus16.parallel_in = drv_par[0];
  assign bus2.mode         = drv_mode[1];
  assign bus2.serial_in    = drv_ser[1];
  assign bus2.parallel_in  = drv_par[1][1:0];

  shift_register_universal #(
    .WIDTH (16), .TICK_DIV (4), .RESET_VALUE (16'h0000)
  ) dut16 (
    .clk_100MHz (clk_100MHz), .reset_n (reset_n), .bus (bus16.slave)
  );

  shift_register_universal #(
    .WIDTH (2), .TICK_DIV (1), .RESET_VALUE (2'b00)
  ) dut2 (
    .clk_100MHz (clk_100MHz), .reset_n (reset_n), .bus (bus2.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // k = clock edges since reset release. The strobe is high after edge k
  // when k is a positive multiple of TICK_DIV; the register changes on the
  // following edge using the inputs as they stood two edges earlier.
  typedef struct {
    logic [1:0]  m;
    logic        s;
    logic [15:0] p;
  } samp_t;

  int    mw [2] = '{16, 2};
  int    mt [2] = '{4, 1};
  samp_t hist [2][3];
  int    m_reg [2];
  int    m_cnt [2];
  int    m_k   [2];
  bit    m_tick [2];
  bit    upd;
  samp_t use_s;
  int    mask;

  always @(posedge clk_100MHz or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_reg[i]  = 0;
        m_cnt[i]  = 0;
        m_k[i]    = 0;
        m_tick[i] = 1'b0;
        for (int j = 0; j < 3; j++) begin
          hist[i][j].m = 2'b00;
          hist[i][j].s = 1'b0;
          hist[i][j].p = 16'h0;
        end
      end else begin
        upd = m_tick[i];
        m_k[i]++;
        hist[i][2]   = hist[i][1];
        hist[i][1]   = hist[i][0];
        hist[i][0].m = drv_mode[i];
        hist[i][0].s = drv_ser[i];
        hist[i][0].p = drv_par[i];
        mask = (1 << mw[i]) - 1;
        if (upd) begin
          use_s = hist[i][2];
          case (use_s.m)
            2'b01: begin
              m_reg[i] = ((m_reg[i] << 1) | int'(use_s.s)) & mask;
              m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
            end
            2'b10: begin
              m_reg[i] = (m_reg[i] >> 1) | (int'(use_s.s) << (mw[i] - 1));
              m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
            end
            2'b11: begin
              m_reg[i] = int'(use_s.p) & mask;
              m_cnt[i] = 0;
            end
            default: ;
          endcase
        end
        m_tick[i] = (m_k[i] % mt[i]) == 0;
      end
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk_100MHz) begin
    check("par16",  32'(bus16.parallel_out),  32'(m_reg[0]));
    check("msb16",  32'(bus16.serial_out_msb), 32'(m_reg[0][15]));
    check("lsb16",  32'(bus16.serial_out_lsb), 32'(m_reg[0][0]));
    check("tick16", 32'(bus16.tick),           32'(m_tick[0]));
    check("cnt16",  32'(bus16.shift_count),    32'(m_cnt[0]));
    check("par2",   32'(bus2.parallel_out),    32'(m_reg[1]));
    check("msb2",   32'(bus2.serial_out_msb),  32'(m_reg[1][1]));
    check("lsb2",   32'(bus2.serial_out_lsb),  32'(m_reg[1][0]));
    check("tick2",  32'(bus2.tick),            32'(m_tick[1]));
    check("cnt2",   32'(bus2.shift_count),     32'(m_cnt[1]));
  end

  // ---------------- directed + random stimulus ----------------
  task automatic wait_tick16(output int t);
    int n = 0;
    do begin
      @(negedge clk_100MHz);
      n++;
    end while (!bus16.tick && n < 16);
    check("tick_wait", 32'(bus16.tick), 32'd1);
    t = cyc;
  endtask

  // Present inputs, then return on the falling edge just after the update.
  task automatic tick16(input logic [1:0] m, input logic s, input logic [15:0] p,
                        output int t);
    drv_mode[0] = m;
    drv_ser[0]  = s;
    drv_par[0]  = p;
    wait_tick16(t);
    @(negedge clk_100MHz);
  endtask

  initial begin
    int t, prev;
    for (int i = 0; i < 2; i++) begin
      drv_mode[i] = 2'b00;
      drv_ser[i]  = 1'b0;
      drv_par[i]  = 16'h0;
    end
    reset_n = 1'b0;
    repeat (4) @(negedge clk_100MHz);
    check("rst_par",  32'(bus16.parallel_out), 32'h0);
    check("rst_tick", 32'(bus16.tick),         32'h0);
    check("rst_cnt",  32'(bus16.shift_count),  32'h0);
    reset_n = 1'b1;

    // Left shift: five ones then three zeros.
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      tick16(MODE_SHIFT_LEFT, (i < 5), 16'h0, t);
      if (i > 0) check("tick_period", 32'(t - prev), 32'd4);
      prev = t;
    end
    check("left_par", 32'(bus16.parallel_out), 32'h00F8);
    check("left_cnt", 32'(bus16.shift_count),  32'd8);

    // Load then shift right with zeros.
    tick16(MODE_LOAD, 1'b0, 16'hA5A5, t);
    check("load_par", 32'(bus16.parallel_out), 32'hA5A5);
    check("load_cnt", 32'(bus16.shift_count),  32'd0);
    for (int i = 0; i < 4; i++) tick16(MODE_SHIFT_RIGHT, 1'b0, 16'h0, t);
    check("right_par", 32'(bus16.parallel_out),   32'h0A5A);
    check("right_lsb", 32'(bus16.serial_out_lsb), 32'd0);
    check("right_cnt", 32'(bus16.shift_count),    32'd4);

    // Hold with a one-cycle LOAD glitch between ticks.
    tick16(MODE_HOLD, 1'b1, 16'hFFFF, t);
    drv_mode[0] = MODE_LOAD;
    @(negedge clk_100MHz);
    drv_mode[0] = MODE_HOLD;
    wait_tick16(t);
    @(negedge clk_100MHz);
    check("glitch_par", 32'(bus16.parallel_out), 32'h0A5A);
    check("glitch_cnt", 32'(bus16.shift_count),  32'd4);

    // Asynchronous reset in the middle of a prescaler count.
    @(negedge clk_100MHz);
    #2 reset_n = 1'b0;
    #1;
    check("async_par",  32'(bus16.parallel_out), 32'h0);
    check("async_cnt",  32'(bus16.shift_count),  32'h0);
    check("async_tick", 32'(bus16.tick),         32'h0);
    repeat (3) @(negedge clk_100MHz);
    reset_n = 1'b1;

    // Random traffic on both instances, checked against the model.
    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < 2; j++) begin
        drv_mode[j] = 2'($urandom_range(3));
        drv_ser[j]  = 1'($urandom_range(1));
        drv_par[j]  = 16'($urandom);
      end
      @(negedge clk_100MHz);
    end
    drv_mode[1] = MODE_HOLD;
    drv_mode[0] = MODE_HOLD;
    repeat (3) @(negedge clk_100MHz);
    wait_tick16(t);
    @(negedge clk_100MHz);

    // Saturation of the shift counter, then clear by LOAD.
    tick16(MODE_LOAD, 1'b0, 16'h1234, t);
    for (int i = 0; i < 300; i++) tick16(MODE_SHIFT_LEFT, 1'($urandom_range(1)), 16'h0, t);
    check("sat_cnt", 32'(bus16.shift_count), 32'd255);
    tick16(MODE_LOAD, 1'b0, 16'hBEEF, t);
    check("sat_clr_cnt", 32'(bus16.shift_count),  32'd0);
    check("sat_clr_par", 32'(bus16.parallel_out), 32'hBEEF);

    // 2-bit instance, tick every cycle: serial 1,0,1 two cycles late.
    drv_mode[1] = MODE_LOAD;
    drv_par[1]  = 16'h0;
    repeat (4) @(negedge clk_100MHz);
    drv_mode[1] = MODE_SHIFT_LEFT;
    drv_ser[1]  = 1'b1;
    @(negedge clk_100MHz);
    drv_ser[1]  = 1'b0;
    @(negedge clk_100MHz);
    check("edge_lag", 32'(bus2.parallel_out), 32'h0);
    drv_ser[1]  = 1'b1;
    @(negedge clk_100MHz);
    check("edge_seq0", 32'(bus2.parallel_out), 32'h1);
    drv_ser[1]  = 1'b0;
    drv_mode[1] = MODE_HOLD;
    @(negedge clk_100MHz);
    check("edge_seq1", 32'(bus2.parallel_out), 32'h2);
    @(negedge clk_100MHz);
    check("edge_seq2", 32'(bus2.parallel_out), 32'h1);
    @(negedge clk_100MHz);
    check("edge_hold", 32'(bus2.parallel_out), 32'h1);

    repeat (3) @(negedge clk_100MHz);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_register_universal.md
# shift_register_universal

Parametrised successor to the 16-bit switch-driven serial-in/parallel-out shift register. It shifts left or right, holds, or loads in parallel, under a 2-bit mode select. All register updates happen on a slow internal tick derived from the 100 MHz board clock, and the switch inputs are synchronised internally. It sits between board switches/buttons and the LED bank (parallel_out) and can be daisy-chained through its serial outputs.

## Interface
- WIDTH, 16: register width in bits; must be ≥ 2.
- TICK_DIV, 100_000_000: clock cycles per update tick (1 Hz at 100 MHz); must be ≥ 1.
- RESET_VALUE, {WIDTH{1'b0}}: register contents after reset.
- clk_100MHz  input  1  single system clock; all logic is rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- mode  input  2  operation select: 00 HOLD, 01 SHIFT_LEFT, 10 SHIFT_RIGHT, 11 LOAD.
- serial_in  input  1  serial data bit, from a switch.
- parallel_in  input  WIDTH  load data, from switches.
- parallel_out  output  WIDTH  register contents.
- serial_out_msb  output  1  equals parallel_out[WIDTH-1]; chain output for left shifts.
- serial_out_lsb  output  1  equals parallel_out[0]; chain output for right shifts.
- tick  output  1  one-cycle strobe, high on the cycle the register updates.
- shift_count  output  8  number of shifts performed since reset or the last LOAD; saturates at 255.

## Operation
- Synchroniser: mode, serial_in and parallel_in each pass through a 2-flop synchroniser (mode_s, serial_s, parallel_s). Only synchronised values are used downstream.
- Prescaler: counter div_cnt, width $clog2(TICK_DIV) (minimum 1 bit).
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - tick = (div_cnt == TICK_DIV-1), registered so it is glitch-free.
  - With TICK_DIV = 1, tick is high every cycle.
- On the tick edge, mode_s selects the update:
  - HOLD: register unchanged; shift_count unchanged.
  - SHIFT_LEFT: reg <= {reg[WIDTH-2:0], serial_s}; shift_count += 1 (saturating).
  - SHIFT_RIGHT: reg <= {serial_s, reg[WIDTH-1:1]}; shift_count += 1 (saturating).
  - LOAD: reg <= parallel_s; shift_count <= 0.
- Off-tick cycles: register and shift_count hold.
- Mode changes between ticks have no effect; only the value sampled on the tick edge counts.
- Reset (asserted at any time, including mid-count or mid-shift):
  - reg = RESET_VALUE, div_cnt = 0, tick = 0, shift_count = 0, all synchroniser flops = 0.
  - Every output takes its reset value immediately and asynchronously.
  - Deassertion is synchronised on-chip by the top level. The block does not re-synchronise it.

## Timing
- Input-to-use latency is 2 cycles (synchroniser). An input change is guaranteed to be captured only if it is stable for ≥ 3 cycles before the tick edge.
- The first tick occurs TICK_DIV cycles after reset release; ticks then repeat every TICK_DIV cycles.
- parallel_out, serial_out_* and shift_count change on the same edge on which tick is sampled high. They are registered outputs with no combinational path from any input.
- Saturation: once shift_count = 255, further shifts leave it at 255. A LOAD on that tick clears it to 0.

## Structure
- Shared package/header shift_register_pkg:
  - mode localparams MODE_HOLD, MODE_SHIFT_LEFT, MODE_SHIFT_RIGHT, MODE_LOAD;
  - COUNT_W = 8;
  - a function computing the prescaler width.
- Sub-module tick_generator, parameter TICK_DIV: ports clk_100MHz, reset_n, tick. It is reusable by other slow-display blocks.
- Top-level module: synchroniser flops, datapath mux, saturating counter.

## Test plan
- Reset: hold reset_n = 0 with clock running → parallel_out = RESET_VALUE, tick = 0, shift_count = 0. Pull reset_n low mid-count → outputs return immediately to reset values.
- Left shift (WIDTH=16, TICK_DIV=4): mode=01, serial_in=1 for 5 ticks, then 0 for 3 ticks → parallel_out = 16'h00F8, shift_count = 8; tick period = 4 cycles.
- Right shift and load: LOAD 16'hA5A5, then SHIFT_RIGHT with serial_in=0 for 4 ticks → 16'h0A5A, serial_out_lsb = 0; shift_count = 0 right after the LOAD and 4 at the end.
- Hold and mode glitch: mode=HOLD, pulse mode to 11 for 1 cycle between ticks → register unchanged, shift_count unchanged.
- Saturation (TICK_DIV=1): 300 consecutive SHIFT_LEFT ticks → shift_count = 255. Next LOAD → 0.
- Edge parameters: WIDTH=2, TICK_DIV=1, shift left with serial_in = 1,0,1 → parallel_out sequence 01, 10, 01, lagging the input by exactly 2 cycles of synchroniser latency.
